// File: rtl/cpu15_pkg.sv
// Shared CPU constants and the write-back entry type.
package cpu15_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned N_REGS     = 8;
  localparam int unsigned REG_IDX_W  = 3;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back buffer: power-of-two depth, pointers wrap naturally.
import cpu15_pkg::*;

module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  wb_entry_t        din_i,
  input  logic             pop_i,
  output wb_entry_t        dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Overflow/underflow requests are dropped here as well as upstream.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop_ok)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/reg_wb.sv
// Write-back stage: buffers requests, commits one per cycle into the register
// file and tracks per-register pending-write busy bits for decode.
import cpu15_pkg::*;

module reg_wb #(
  parameter int unsigned FIFO_DEPTH = cpu15_pkg::FIFO_DEPTH
) (
  input  logic                               CLK_WB,
  input  logic                               RSTN_WB,
  input  logic                               WB_VALID,
  output logic                               WB_READY,
  input  logic [REG_IDX_W-1:0]               WB_N_REG,
  input  logic [DATA_W-1:0]                  WB_DATA,
  input  logic                               COMMIT_EN,
  input  logic                               ISSUE_VALID,
  input  logic [REG_IDX_W-1:0]               ISSUE_N_REG,
  output logic [DATA_W-1:0]                  REG_0,
  output logic [DATA_W-1:0]                  REG_1,
  output logic [DATA_W-1:0]                  REG_2,
  output logic [DATA_W-1:0]                  REG_3,
  output logic [DATA_W-1:0]                  REG_4,
  output logic [DATA_W-1:0]                  REG_5,
  output logic [DATA_W-1:0]                  REG_6,
  output logic [DATA_W-1:0]                  REG_7,
  output logic [N_REGS-1:0]                  REG_BUSY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_CNT
);

  wb_entry_t         push_entry, head;
  logic              full, empty;
  logic              push, pop;
  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [N_REGS-1:0] busy_q, busy_d;

  assign push_entry = '{idx: WB_N_REG, data: WB_DATA};
  // WB_READY has no pop look-ahead, so a full buffer refuses even when draining.
  assign WB_READY   = !full;
  assign push       = WB_VALID && !full;
  assign pop        = COMMIT_EN && !empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_WB),
    .rstn_i  (RSTN_WB),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (FIFO_CNT)
  );

  // Register file: the FIFO head is written on commit.
  always_ff @(posedge CLK_WB) begin
    if (!RSTN_WB) begin
      regs_q <= '{default: '0};
    end else if (pop) begin
      regs_q[head.idx] <= head.data;
    end
  end

  // Scoreboard next state: commit clears, issue sets, set applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (pop)         busy_d[head.idx]    = 1'b0;
    if (ISSUE_VALID) busy_d[ISSUE_N_REG] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge CLK_WB) begin
    if (!RSTN_WB) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign REG_BUSY = busy_q;
  assign REG_0    = regs_q[0];
  assign REG_1    = regs_q[1];
  assign REG_2    = regs_q[2];
  assign REG_3    = regs_q[3];
  assign REG_4    = regs_q[4];
  assign REG_5    = regs_q[5];
  assign REG_6    = regs_q[6];
  assign REG_7    = regs_q[7];

endmodule

// File: tb/tb_reg_wb.sv
// Directed + random bench for reg_wb with a queue-based commit scoreboard.
module tb_reg_wb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_n_reg;
  logic [15:0] wb_data;
  logic        commit_en;
  logic        issue_valid;
  logic [2:0]  issue_n_reg;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  reg_busy;
  logic [1:0]  fifo_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Scoreboard: accepted entries {idx,data} awaiting commit, plus expected state.
  logic [18:0] exp_q [$];
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;

  always #5 clk = ~clk;

  reg_wb #(
    .FIFO_DEPTH (2)
  ) dut (
    .CLK_WB      (clk),
    .RSTN_WB     (rstn),
    .WB_VALID    (wb_valid),
    .WB_READY    (wb_ready),
    .WB_N_REG    (wb_n_reg),
    .WB_DATA     (wb_data),
    .COMMIT_EN   (commit_en),
    .ISSUE_VALID (issue_valid),
    .ISSUE_N_REG (issue_n_reg),
    .REG_0       (r0),
    .REG_1       (r1),
    .REG_2       (r2),
    .REG_3       (r3),
    .REG_4       (r4),
    .REG_5       (r5),
    .REG_6       (r6),
    .REG_7       (r7),
    .REG_BUSY    (reg_busy),
    .FIFO_CNT    (fifo_cnt)
  );

  function automatic logic [15:0] dut_reg(input int unsigned n);
    case (n)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      5: return r5;
      6: return r6;
      default: return r7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after it.
  task automatic cyc(input logic rst_n, input logic v, input logic [2:0] idx,
                     input logic [15:0] data, input logic c,
                     input logic iv, input logic [2:0] iidx);
    logic        acc, com;
    logic [18:0] e;
    rstn        = rst_n;
    wb_valid    = v;
    wb_n_reg    = idx;
    wb_data     = data;
    commit_en   = c;
    issue_valid = iv;
    issue_n_reg = iidx;
    acc = v && (exp_q.size() < 2);
    com = c && (exp_q.size() > 0);
    if (rst_n) chk("ready_pre", {31'b0, wb_ready}, {31'b0, exp_q.size() < 2});
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_regs = '{default: '0};
      m_busy = '0;
    end else begin
      if (com) begin
        e = exp_q.pop_front();
        m_regs[e[18:16]] = e[15:0];
        m_busy[e[18:16]] = 1'b0;
      end
      if (iv)  m_busy[iidx] = 1'b1;
      if (acc) exp_q.push_back({idx, data});
    end
    #1;
    for (int unsigned n = 0; n < 8; n++)
      chk($sformatf("reg%0d", n), {16'b0, dut_reg(n)}, {16'b0, m_regs[n]});
    chk("busy", {24'b0, reg_busy}, {24'b0, m_busy});
    chk("cnt", {30'b0, fifo_cnt}, exp_q.size());
  endtask

  initial begin
    m_regs = '{default: '0};
    m_busy = '0;

    // Reset held two cycles with a request pending.
    cyc(1'b0, 1'b1, 3'd5, 16'h1111, 1'b1, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 3'd5, 16'h1111, 1'b1, 1'b1, 3'd2);
    chk("rst_busy", {24'b0, reg_busy}, 32'h0);
    chk("rst_cnt", {30'b0, fifo_cnt}, 32'h0);
    chk("rst_reg5", {16'b0, r5}, 32'h0);
    rstn = 1'b1; wb_valid = 1'b0; #1;
    chk("rst_ready", {31'b0, wb_ready}, 32'h1);

    // Single write: accept edge k, commit edge k+1.
    cyc(1'b1, 1'b1, 3'd3, 16'hABCD, 1'b1, 1'b0, 3'd0);
    chk("single_not_yet", {16'b0, r3}, 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    chk("single_reg3", {16'b0, r3}, 32'hABCD);
    chk("single_cnt", {30'b0, fifo_cnt}, 32'h0);

    // Stall until full; third push refused.
    cyc(1'b1, 1'b1, 3'd1, 16'h7628, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 3'd5, 16'h34B1, 1'b0, 1'b0, 3'd0);
    chk("full_cnt", {30'b0, fifo_cnt}, 32'h2);
    chk("full_ready", {31'b0, wb_ready}, 32'h0);
    cyc(1'b1, 1'b1, 3'd2, 16'h7E6E, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    chk("drain_reg1", {16'b0, r1}, 32'h7628);
    chk("drain_reg5_old", {16'b0, r5}, 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    chk("drain_reg5", {16'b0, r5}, 32'h34B1);
    chk("drain_reg2", {16'b0, r2}, 32'h0);

    // Same register back-to-back: last one wins.
    cyc(1'b1, 1'b1, 3'd7, 16'h808D, 1'b1, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 3'd7, 16'h1234, 1'b1, 1'b0, 3'd0);
    chk("order_first", {16'b0, r7}, 32'h808D);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    chk("order_last", {16'b0, r7}, 32'h1234);

    // Scoreboard: set-wins on simultaneous set/clear, then plain clear.
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4);
    chk("sb_set", {24'b0, reg_busy}, 32'h10);
    cyc(1'b1, 1'b1, 3'd4, 16'h64A6, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd4);
    chk("sb_setwins", {24'b0, reg_busy}, 32'h10);
    chk("sb_reg4", {16'b0, r4}, 32'h64A6);
    cyc(1'b1, 1'b1, 3'd4, 16'h0BEE, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    chk("sb_clear", {24'b0, reg_busy}, 32'h0);

    // Reset mid-flight discards buffered entries and busy bits.
    cyc(1'b1, 1'b1, 3'd1, 16'hAAAA, 1'b0, 1'b1, 3'd1);
    cyc(1'b1, 1'b1, 3'd5, 16'hBBBB, 1'b0, 1'b1, 3'd5);
    chk("mid_cnt", {30'b0, fifo_cnt}, 32'h2);
    chk("mid_busy", {24'b0, reg_busy}, 32'h22);
    cyc(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    for (int unsigned k = 0; k < 3; k++)
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0);
    chk("mid_reg1", {16'b0, r1}, 32'h0);
    chk("mid_reg5", {16'b0, r5}, 32'h0);

    // Random mixed traffic against the scoreboard.
    for (int unsigned k = 0; k < 60; k++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          16'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
